// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Definitions shared by the ALU mini project: the adder, the bit-serial
//   subtractor and the ALU top.
//   - DEFAULT_WIDTH : default operand width
//   - *_CODE        : 2-bit encodings of the serial FSM states
//   - state_t       : enum built on those encodings
//   - sub_ref       : reference difference A-B in WIDTH+1 bits
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int DEFAULT_WIDTH = 3;

   localparam logic [1:0] IDLE_CODE  = 2'd0;
   localparam logic [1:0] LOAD_CODE  = 2'd1;
   localparam logic [1:0] SHIFT_CODE = 2'd2;
   localparam logic [1:0] DONE_CODE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = IDLE_CODE,
      LOAD  = LOAD_CODE,
      SHIFT = SHIFT_CODE,
      DONE  = DONE_CODE
   } state_t;

   // Two's-complement A-B for DEFAULT_WIDTH operands. The result never
   // overflows because the extra bit is the final borrow.
   function automatic logic [DEFAULT_WIDTH:0] sub_ref(
      input logic [DEFAULT_WIDTH-1:0] a,
      input logic [DEFAULT_WIDTH-1:0] b
   );
      return {1'b0, a} - {1'b0, b};
   endfunction

endpackage

// File: rtl/serial_sub_if.sv
// ---------------------------------------------------------------------------
// serial_sub_if
//   Request/result bundle of the bit-serial subtractor.
//
//   Handshake: the master raises start with A/B valid. The slave samples
//   start only while idle (busy=0). The request is accepted at the first
//   rising edge where the slave is in IDLE and start=1. Starts seen while
//   busy are dropped, not queued. The result appears on out together with
//   a one-cycle done pulse. out then holds until the next done.
//
//   Signals:
//     start  master->slave  request
//     A, B   master->slave  unsigned minuend / subtrahend
//     out    slave->master  {final_borrow, diff}, WIDTH+1 bits
//     busy   slave->master  operation in flight (LOAD/SHIFT)
//     done   slave->master  one-cycle result strobe
//     zero   slave->master  result==0, only with SERIAL_SUB_ZERO_FLAG_EN
// ---------------------------------------------------------------------------
interface serial_sub_if #(
   parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH:0]   out;
   logic             busy;
   logic             done;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
   logic             zero;
`endif

`ifdef SERIAL_SUB_ZERO_FLAG_EN
   modport master (output start, A, B, input out, busy, done, zero);
   modport slave  (input start, A, B, output out, busy, done, zero);
`else
   modport master (output start, A, B, input out, busy, done);
   modport slave  (input start, A, B, output out, busy, done);
`endif
endinterface

// File: rtl/full_sub_bit.sv
// ---------------------------------------------------------------------------
// full_sub_bit
//   1-bit full subtractor: computes a - b - bin.
//     a, b, bin : minuend bit, subtrahend bit, borrow in
//     d         : difference bit
//     bout      : borrow out
// ---------------------------------------------------------------------------
module full_sub_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   // Borrow when a=0,b=1, or when the bits are equal and a borrow ripples in.
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub
//   Bit-serial subtractor: out = A - B, with the operands processed LSB
//   first, one bit per clock, through a single full_sub_bit and a borrow
//   flop.
//   The FSM runs IDLE -> LOAD -> SHIFT (WIDTH cycles) -> DONE -> IDLE.
//   done pulses in the IDLE cycle after DONE, which is also the first cycle
//   a new start may be sampled.
//
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     bus        serial_sub_if.slave (start, A, B, out, busy, done[, zero])
//     state_dbg  current FSM state
//
//   Build option: with SERIAL_SUB_ZERO_FLAG_EN defined, bus.zero reports
//   out==0. It is updated together with out.
// ---------------------------------------------------------------------------
module serial_sub
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic        clk,
   input  logic        rst,
   serial_sub_if.slave bus,
   output state_t      state_dbg
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   out_r;
   logic [WIDTH:0]   out_next;
   logic             busy_r;
   logic             done_r;
   logic             d_bit;
   logic             bout_bit;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
   logic             zero_r;
`endif

   full_sub_bit u_bit (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow),
      .d    (d_bit),
      .bout (bout_bit)
   );

   assign out_next = {borrow, diff};

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         diff   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         out_r  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
         zero_r <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  state  <= LOAD;
                  busy_r <= 1'b1;
               end
            end
            LOAD: begin
               a_sr   <= bus.A;
               b_sr   <= bus.B;
               borrow <= 1'b0;
               cnt    <= '0;
               state  <= SHIFT;
            end
            SHIFT: begin
               // The new difference bit enters at the MSB. After WIDTH
               // shifts, the first-computed bit has reached bit 0.
               diff   <= WIDTH'({d_bit, diff} >> 1);
               borrow <= bout_bit;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state  <= DONE;
                  busy_r <= 1'b0;
               end
            end
            DONE: begin
               out_r  <= out_next;
               done_r <= 1'b1;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
               zero_r <= (out_next == '0);
`endif
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.out   = out_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
   assign bus.zero  = zero_r;
`endif
   assign state_dbg = state;

endmodule

// File: tb/tb_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_sub
//   Self-checking bench for serial_sub (WIDTH=3). Inputs are driven and
//   outputs are sampled on the falling edge. Expected results are queued
//   when a start is driven and popped when done is seen.
// ---------------------------------------------------------------------------
module tb_serial_sub;
   import alu_pkg::*;

   localparam int W       = 3;
   localparam int TIMEOUT = 20;

   logic   clk;
   logic   rst;
   state_t state_dbg;

   serial_sub_if #(.WIDTH(W)) bus ();

   serial_sub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   int n_pass  = 0;
   int n_total = 0;
   logic [W:0] exp_q[$];

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   // Called at a falling edge. Presents a one-cycle start and returns at the
   // falling edge after the sampling rising edge.
   task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      exp_q.push_back(sub_ref(a, b));
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Counts rising edges after the sampling edge until done is seen.
   task automatic wait_done(output int c, output bit seen);
      c    = 0;
      seen = 1'b0;
      while (!seen && c < TIMEOUT) begin
         if (bus.done) seen = 1'b1;
         else begin
            @(negedge clk);
            c++;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++;
      if (bus.out !== 4'b0000) $display("FAIL reset_out: got %b want 0000", bus.out);
      else n_pass++;
      n_total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL reset_flags: busy=%b done=%b want 0 0", bus.busy, bus.done);
      else n_pass++;
      n_total++;
      if (state_dbg !== IDLE) $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
      else n_pass++;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      n_total++;
      if (bus.zero !== 1'b0) $display("FAIL reset_zero: got %b want 0", bus.zero);
      else n_pass++;
`endif
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int c;
      bit seen;
      logic [W:0] e;
      drive_start(3'b000, 3'b001);
      n_total++;
      if (bus.busy !== 1'b1 || state_dbg !== LOAD)
         $display("FAIL basic_busy: busy=%b state=%0d want 1 %0d", bus.busy, state_dbg, LOAD);
      else n_pass++;
      wait_done(c, seen);
      e = exp_q.pop_front();
      n_total++;
      if (!seen) $display("FAIL basic_timeout: no done within %0d cycles", TIMEOUT);
      else if (c !== W + 2) $display("FAIL basic_latency: got %0d want %0d", c, W + 2);
      else n_pass++;
      n_total++;
      if (bus.out !== e || e !== 4'b1111) $display("FAIL basic_out: got %b want 1111", bus.out);
      else n_pass++;
      n_total++;
      if (bus.busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", bus.busy);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (bus.done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", bus.done);
      else n_pass++;
   endtask

   task automatic test_zero;
      int c;
      bit seen;
      logic [W:0] e;
      drive_start(3'b101, 3'b101);
      wait_done(c, seen);
      e = exp_q.pop_front();
      n_total++;
      if (!seen || bus.out !== e)
         $display("FAIL zero_out: seen=%b got %b want %b", seen, bus.out, e);
      else n_pass++;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      n_total++;
      if (bus.zero !== 1'b1) $display("FAIL zero_flag: got %b want 1", bus.zero);
      else n_pass++;
`endif
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int c;
      bit seen;
      logic [W:0] e;
      drive_start(3'b110, 3'b011);
      wait_done(c, seen);
      e = exp_q.pop_front();
      n_total++;
      if (!seen || bus.out !== 4'b0011 || e !== 4'b0011)
         $display("FAIL b2b_first: seen=%b got %b want 0011", seen, bus.out);
      else n_pass++;
      // Second start is driven during the done cycle.
      drive_start(3'b000, 3'b111);
      wait_done(c, seen);
      e = exp_q.pop_front();
      n_total++;
      if (!seen || c !== W + 2)
         $display("FAIL b2b_second_latency: seen=%b got %0d want %0d", seen, c, W + 2);
      else n_pass++;
      n_total++;
      if (bus.out !== 4'b1001 || e !== 4'b1001)
         $display("FAIL b2b_second_out: got %b want 1001", bus.out);
      else n_pass++;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      n_total++;
      if (bus.zero !== 1'b0) $display("FAIL b2b_zero: got %b want 0", bus.zero);
      else n_pass++;
`endif
      @(negedge clk);
   endtask

   task automatic test_hold_start;
      int c;
      int n_done;
      bit seen;
      logic [W:0] e;
      bus.start = 1'b1;
      bus.A     = 3'b010;
      bus.B     = 3'b001;
      exp_q.push_back(sub_ref(3'b010, 3'b001));
      @(negedge clk);
      c = 0;
      seen = 1'b0;
      while (!seen && c < TIMEOUT) begin
         if (bus.done) seen = 1'b1;
         else begin
            @(negedge clk);
            c++;
            if (c == 2 || c == 3) begin
               bus.A = W'($urandom_range(0, 7));
               bus.B = W'($urandom_range(0, 7));
            end
         end
      end
      bus.start = 1'b0;
      e = exp_q.pop_front();
      n_total++;
      if (!seen || c !== W + 2)
         $display("FAIL hold_latency: seen=%b got %0d want %0d", seen, c, W + 2);
      else n_pass++;
      n_total++;
      if (bus.out !== e || e !== 4'b0001)
         $display("FAIL hold_out: got %b want 0001", bus.out);
      else n_pass++;
      n_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      n_total++;
      if (n_done !== 0) $display("FAIL hold_extra_done: got %0d want 0", n_done);
      else n_pass++;
   endtask

   task automatic test_reset_abort;
      int c;
      int n_done;
      bit seen;
      logic [W:0] e;
      drive_start(3'b110, 3'b011);
      wait_done(c, seen);
      e = exp_q.pop_front();
      n_total++;
      if (!seen || bus.out !== e)
         $display("FAIL abort_prior: seen=%b got %b want %b", seen, bus.out, e);
      else n_pass++;
      @(negedge clk);
      drive_start(3'b111, 3'b000);
      void'(exp_q.pop_back());   // this operation is aborted and never reports
      repeat (2) @(negedge clk);
      n_total++;
      if (state_dbg !== SHIFT || bus.out !== 4'b0011)
         $display("FAIL abort_hold: state=%0d out=%b want %0d 0011", state_dbg, bus.out, SHIFT);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if (bus.out !== 4'b0000 || bus.busy !== 1'b0 || state_dbg !== IDLE)
         $display("FAIL abort_reset: out=%b busy=%b state=%0d want 0000 0 %0d",
                  bus.out, bus.busy, state_dbg, IDLE);
      else n_pass++;
      rst = 1'b0;
      n_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      n_total++;
      if (n_done !== 0 || bus.out !== 4'b0000)
         $display("FAIL abort_no_done: dones=%0d out=%b want 0 0000", n_done, bus.out);
      else n_pass++;
   endtask

   task automatic test_sweep;
      int c;
      int n_bad;
      bit seen;
      logic [W:0] e;
      n_bad = 0;
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            drive_start(W'(a), W'(b));
            wait_done(c, seen);
            e = exp_q.pop_front();
            n_total++;
            if (!seen || bus.out !== e) begin
               $display("FAIL sweep %0d-%0d: seen=%b got %b want %b", a, b, seen, bus.out, e);
               n_bad++;
            end else n_pass++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      n_total++;
      if (exp_q.size() !== 0) $display("FAIL sweep_queue: %0d left want 0", exp_q.size());
      else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_zero();
      test_back_to_back();
      test_hold_start();
      test_reset_abort();
      test_sweep();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
